// File: rtl/debounce_pkg.sv
// Shared defaults and the threshold clamp for the multi-channel debouncer.
package debounce_pkg;
  localparam int DEF_CHANNELS    = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_COUNT_W     = 16;
  localparam int MAX_COUNT_W     = 32;

  // A threshold of zero would never qualify, so it behaves like one tick.
  function automatic logic [MAX_COUNT_W-1:0] eff_thresh(input logic [MAX_COUNT_W-1:0] t);
    return (t == '0) ? MAX_COUNT_W'(1) : t;
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser, stability counter, filtered level and edge pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int   COUNT_W     = DEF_COUNT_W,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [COUNT_W-1:0] thr_m1_i,
  input  logic               in_i,
  output logic               out_o,
  output logic               rise_o,
  output logic               fall_o,
  output logic               edge_d_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_prev_q;
  logic [COUNT_W-1:0]     cnt_q, cnt_d;
  logic                   out_q, out_d, rise_q, rise_d, fall_q, fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  // cnt never exceeds thr_m1_i, so the increment cannot wrap even at the max threshold.
  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s != s_prev_q || s == out_q) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q >= thr_m1_i) begin
        cnt_d  = '0;
        out_d  = s;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt_q + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= {SYNC_STAGES{RESET_VAL}};
      s_prev_q <= RESET_VAL;
      cnt_q    <= '0;
      out_q    <= RESET_VAL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], in_i};
      s_prev_q <= s;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign out_o    = out_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign edge_d_o = rise_d | fall_d;
endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounce channels sharing one threshold and count-enable tick.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int                  CHANNELS    = DEF_CHANNELS,
  parameter int                  SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int                  COUNT_W     = DEF_COUNT_W,
  parameter logic [CHANNELS-1:0] RESET_VAL   = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic [COUNT_W-1:0]  thresh_i,
  input  logic [CHANNELS-1:0] in_i,
  output logic [CHANNELS-1:0] out_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic                changed_o
);
  logic [COUNT_W-1:0]  thr_m1;
  logic [CHANNELS-1:0] edge_d;
  logic                changed_q;

  // Channels compare against T-1; T is at least 1 so this never underflows.
  assign thr_m1 = COUNT_W'(eff_thresh(MAX_COUNT_W'(thresh_i)) - MAX_COUNT_W'(1));

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .COUNT_W    (COUNT_W),
      .RESET_VAL  (RESET_VAL[i])
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en_i    (en_i),
      .thr_m1_i(thr_m1),
      .in_i    (in_i[i]),
      .out_o   (out_o[i]),
      .rise_o  (rise_o[i]),
      .fall_o  (fall_o[i]),
      .edge_d_o(edge_d[i])
    );
  end

  // Built from the channels' next-state edges so it lines up with rise_o/fall_o.
  always_ff @(posedge clk) begin
    if (rst) changed_q <= 1'b0;
    else     changed_q <= |edge_d;
  end

  assign changed_o = changed_q;
endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with a tick-counting reference model checked every cycle.
module tb_debounce_bank;
  localparam int         CH = 4;
  localparam int         SS = 2;
  localparam int         CW = 16;
  localparam logic [3:0] RV = 4'b1010;

  logic          clk = 1'b0;
  logic          rst, en_i;
  logic [CW-1:0] thresh_i;
  logic [CH-1:0] in_i, out_o, rise_o, fall_o;
  logic          changed_o;

  int total = 0;
  int bad   = 0;

  debounce_bank #(.CHANNELS(CH), .SYNC_STAGES(SS), .COUNT_W(CW), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .thresh_i(thresh_i), .in_i(in_i),
    .out_o(out_o), .rise_o(rise_o), .fall_o(fall_o), .changed_o(changed_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: raw samples history, and per channel the number of enable
  // ticks seen while the synchronised level has been stable and differs from out.
  logic [3:0] hist [0:SS];
  int         m_ticks [CH];
  logic [3:0] m_out, m_rise, m_fall;
  logic       m_chg;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin : model
    automatic int         t;
    automatic int         nt [CH];
    automatic logic [3:0] no, nr, nf;
    automatic logic       s, sp;
    if (rst) begin
      for (int k = 0; k <= SS; k++) hist[k] <= RV;
      for (int i = 0; i < CH; i++) nt[i] = 0;
      m_ticks <= nt;
      m_out   <= RV;
      m_rise  <= '0;
      m_fall  <= '0;
      m_chg   <= 1'b0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      t  = (thresh_i == 0) ? 1 : int'(thresh_i);
      no = m_out;
      nr = '0;
      nf = '0;
      for (int i = 0; i < CH; i++) begin
        s     = hist[SS-1][i];
        sp    = hist[SS][i];
        nt[i] = m_ticks[i];
        if (s != sp || s == m_out[i]) nt[i] = 0;
        else if (en_i) begin
          nt[i] = nt[i] + 1;
          if (nt[i] >= t) begin
            nt[i] = 0;
            no[i] = s;
            if (s) nr[i] = 1'b1;
            else   nf[i] = 1'b1;
          end
        end
      end
      m_ticks <= nt;
      m_out   <= no;
      m_rise  <= nr;
      m_fall  <= nf;
      m_chg   <= |(nr | nf);
      hist[0] <= in_i;
      for (int k = 1; k <= SS; k++) hist[k] <= hist[k-1];
    end
  end

  always @(negedge clk) begin : compare
    if (m_valid)
      chk("model", {19'd0, out_o, rise_o, fall_o, changed_o},
                   {19'd0, m_out, m_rise, m_fall, m_chg});
  end

  initial begin
    rst = 1'b1; en_i = 1'b1; thresh_i = 16'd4; in_i = RV;
    edges(3);
    chk("reset_out", {28'd0, out_o}, {28'd0, RV});
    chk("reset_pulses", {23'd0, rise_o, fall_o, changed_o}, 32'd0);
    rst = 1'b0;
    edges(5);
    chk("idle_out", {28'd0, out_o}, {28'd0, RV});

    // basic latency: out rises after edge 7 (2 sync + 1 + T=4)
    in_i[0] = 1'b1;
    edges(6);
    chk("lat_e6", {31'd0, out_o[0]}, 32'd0);
    edges(1);
    chk("lat_e7", {23'd0, out_o, rise_o, changed_o}, {23'd0, 4'b1011, 4'b0001, 1'b1});
    edges(1);
    chk("lat_e8", {27'd0, rise_o, changed_o}, 32'd0);

    // glitch rejection, then a 5-cycle pulse
    in_i[2] = 1'b1;
    edges(3);
    in_i[2] = 1'b0;
    edges(12);
    chk("glitch_out", {31'd0, out_o[2]}, 32'd0);
    in_i[2] = 1'b1;
    edges(5);
    in_i[2] = 1'b0;
    edges(2);
    chk("pulse_rise", {30'd0, out_o[2], rise_o[2]}, 32'd3);
    edges(5);
    chk("pulse_fall", {30'd0, out_o[2], fall_o[2]}, 32'd1);

    // ticked enable, T=3, with a long freeze before the last tick
    en_i = 1'b0; thresh_i = 16'd3; in_i[0] = 1'b0;
    edges(3);
    for (int k = 0; k < 2; k++) begin
      en_i = 1'b1; edges(1);
      en_i = 1'b0; edges(9);
    end
    chk("tick2_hold", {31'd0, out_o[0]}, 32'd1);
    edges(50);
    chk("freeze_hold", {31'd0, out_o[0]}, 32'd1);
    en_i = 1'b1; edges(1); en_i = 1'b0;
    chk("tick3_fall", {30'd0, out_o[0], fall_o[0]}, 32'd1);

    // thresh 0 acts as 1, then thresh 1
    en_i = 1'b1; thresh_i = 16'd0; in_i[2] = 1'b1;
    edges(3);
    chk("t0_e3", {31'd0, out_o[2]}, 32'd0);
    edges(1);
    chk("t0_e4", {30'd0, out_o[2], rise_o[2]}, 32'd3);
    thresh_i = 16'd1; in_i[2] = 1'b0;
    edges(3);
    chk("t1_e3", {31'd0, out_o[2]}, 32'd1);
    edges(1);
    chk("t1_e4", {30'd0, out_o[2], fall_o[2]}, 32'd1);

    // lower threshold 100 -> 2 while 50 ticks are accumulated
    thresh_i = 16'd100; in_i[0] = 1'b1;
    edges(53);
    chk("lower_before", {31'd0, out_o[0]}, 32'd0);
    thresh_i = 16'd2;
    edges(1);
    chk("lower_after", {30'd0, out_o[0], rise_o[0]}, 32'd3);

    // maximum threshold completes without wrapping
    thresh_i = 16'hFFFF; in_i[2] = 1'b1;
    edges(65537);
    chk("max_before", {31'd0, out_o[2]}, 32'd0);
    edges(1);
    chk("max_fire", {30'd0, out_o[2], rise_o[2]}, 32'd3);
    edges(5);
    chk("max_hold", {31'd0, out_o[2]}, 32'd1);

    // reset mid-count: pending fall discarded, full latency after release
    thresh_i = 16'd4; in_i[1] = 1'b0;
    edges(4);
    rst = 1'b1;
    edges(2);
    chk("midrst_out", {28'd0, out_o}, {28'd0, RV});
    chk("midrst_pulses", {23'd0, rise_o, fall_o, changed_o}, 32'd0);
    rst = 1'b0;
    edges(6);
    chk("midrst_e6", {31'd0, out_o[1]}, 32'd1);
    edges(1);
    chk("midrst_e7", {30'd0, out_o[1], fall_o[1]}, 32'd1);

    // all channels rise on the same edge
    in_i = 4'h0;
    edges(10);
    in_i = 4'hF;
    edges(6);
    chk("simul_e6", {28'd0, rise_o}, 32'd0);
    edges(1);
    chk("simul_e7", {23'd0, rise_o, fall_o, changed_o}, {23'd0, 4'hF, 4'h0, 1'b1});
    edges(1);
    chk("simul_e8", {27'd0, rise_o, changed_o}, 32'd0);

    edges(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/debounce_bank.md
# debounce_bank

Multi-channel, runtime-configurable debouncer. It is the parametrised successor to the single-bit debouncer. It synchronises `CHANNELS` asynchronous inputs (buttons, switches, slow status lines) and holds each filtered output until its input has been stable for a programmable number of enable ticks. It also produces per-channel rising and falling edge pulses. It sits between board I/O pads and control logic, and typically shares a slow tick from a prescaler on `en_i`.

## Interface

Parameters:
- `CHANNELS`, default 8: number of independent channels (≥1).
- `SYNC_STAGES`, default 2: synchroniser flops per channel (≥2).
- `COUNT_W`, default 16: width of the stability counter and threshold.
- `RESET_VAL`, default `'0`: `CHANNELS`-bit reset value for the synchroniser, the change-detect register and `out_o`.

Ports (one clock; reset is synchronous and active-high):
- `clk`, input, 1: clock.
- `rst`, input, 1: synchronous, active-high reset.
- `en_i`, input, 1: count-enable tick. The counters advance only when this is high.
- `thresh_i`, input, `COUNT_W`: required number of stable ticks. A value of 0 is treated as 1. Sampled every cycle.
- `in_i`, input, `CHANNELS`: raw asynchronous inputs.
- `out_o`, output, `CHANNELS`: debounced levels.
- `rise_o`, output, `CHANNELS`: one-cycle pulse when `out_o[i]` goes 0→1.
- `fall_o`, output, `CHANNELS`: one-cycle pulse when `out_o[i]` goes 1→0.
- `changed_o`, output, 1: OR of all `rise_o` and `fall_o` bits (registered).

## Operation

Each channel `i` is independent and has the following registers:
- `sync[SYNC_STAGES]`: the synchroniser chain. `s` is the last stage.
- `s_prev`: `s` delayed by one cycle.
- `cnt`: a `COUNT_W`-bit counter.
- `out_o[i]`.

The effective threshold is `T = (thresh_i == 0) ? 1 : thresh_i`.

The counter is updated each cycle with the following priority:
1. If `s != s_prev` (input moved) or `s == out_o[i]` (no pending change), then `cnt <= 0`.
2. Else, if `en_i` and `cnt >= T-1`, then `out_o[i] <= s` and `cnt <= 0`.
3. Else, if `en_i`, then `cnt <= cnt + 1`.
4. Otherwise `cnt` holds.

Edge and change outputs:
- `rise_o[i]` and `fall_o[i]` are registered. They assert in the same cycle that the new `out_o[i]` value first appears, for exactly one cycle.
- `changed_o` follows the same timing.

Boundary rules:
- **Glitch rejection:** any toggle of `s` before `T` qualifying ticks restarts the count from 0. A pulse that returns to the current `out_o` level also clears the count.
- **Threshold lowered mid-count:** because the compare is `>=`, the channel updates on the next qualifying tick. The counter never wraps.
- **Threshold raised mid-count:** counting continues up to the new `T-1`.
- **Maximum threshold:** `thresh_i = 2^COUNT_W - 1` must work without overflow; `cnt` stays ≤ `T-1`.
- **`en_i` low:** counters freeze. Clearing on input movement still happens.

Reset:
- `rst` high resets all `sync` stages, `s_prev` and `out_o` to `RESET_VAL`.
- All `cnt` registers clear to 0.
- `rise_o`, `fall_o` and `changed_o` clear to 0.
- Reset must not produce an edge pulse. Reset asserted mid-count discards the pending change.

## Timing

- **Latency with `en_i` held high:** the input changes at edge 0 and stays stable. `out_o[i]` changes after edge `SYNC_STAGES + 1 + T`.
- **Latency with a ticked `en_i`:** `SYNC_STAGES + 1` cycles, then `T` qualifying ticks, then the update on the clock edge of the `T`-th tick.
- **Throughput:** one output transition per channel per `T` ticks at most. Channels never stall each other.
- **Pulse alignment:** `rise_o`, `fall_o` and `changed_o` are coincident with the `out_o` transition. No combinational path exists from any input to any output.

## Structure

- **Package `debounce_pkg`:** holds the default-parameter constants and a helper function for the effective threshold (0→1 clamp).
- **Sub-module `debounce_channel`:** contains one channel's synchroniser, counter, output and edge registers. The top level instantiates it `CHANNELS` times in a generate loop. The top level holds only the shared `T` computation and the registered `changed_o` OR-reduction.
- **Size:** about 150–250 lines in total.

## Test plan

- **Basic latency:** `CHANNELS=4`, `SYNC_STAGES=2`, `en_i=1`, `thresh_i=4`. Drive `in_i[0]` 0→1 and hold. Then `out_o[0]` goes high after edge 7; `rise_o[0]` and `changed_o` are high for that one cycle only; other channels stay 0.
- **Glitch rejection:** `thresh_i=4`. Apply a 3-cycle high pulse on `in_i[1]`. Then `out_o[1]` stays 0 and no pulses occur. A 5-cycle pulse followed by a low level produces a rise, then later a fall, each 7 cycles after its input edge.
- **Ticked enable:** `en_i` is high 1 cycle in 10, `thresh_i=3`. After a stable input change, `out_o` updates on the 3rd tick after synchronisation, not earlier. Freezing `en_i` low holds `cnt` indefinitely.
- **Threshold corner cases:** `thresh_i=0` behaves exactly like `thresh_i=1`. Lowering `thresh_i` from 100 to 2 while `cnt=50` updates the output on the next tick. Running `thresh_i=16'hFFFF` to completion shows no wrap.
- **Reset:** with `RESET_VAL=4'b1010`, check that the reset values match and no pulses appear after reset release. Assert `rst` mid-count and hold `in_i` at the new value: the count restarts from 0, with full latency after release.
- **Simultaneous events:** all channels toggle on the same edge. Then all `rise_o` bits assert in the same cycle and `changed_o` pulses once for one cycle.
